// File: rtl/riscv_lsu_defs.sv
// Shared load/store encodings: store funct3 codes, store FSM states, base byte-enable patterns.
package riscv_lsu_defs;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } st_state_t;

endpackage

// File: rtl/riscv_store_lane.sv
// Combinational store lane mapper: rs2 data + byte offset -> lane-aligned words, 8-bit mask, split flag.
// The high word port exists only when RISCV_STORE_SPLIT_EN is defined.
module riscv_store_lane
    import riscv_lsu_defs::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
`ifdef RISCV_STORE_SPLIT_EN
    output logic [31:0] o_hi_word,
`endif
    output logic [31:0] o_lo_word,
    output logic [7:0]  o_mask8,
    output logic        o_split
);

    logic [31:0] w_rep;
    logic [3:0]  w_be;
    logic        w_is_sb;

    always_comb begin
        w_rep   = i_wdata;
        w_be    = BE_WORD;
        w_is_sb = 1'b0;
        case (i_funct3)
            F3_SB: begin
                w_rep   = {4{i_wdata[7:0]}};
                w_be    = BE_BYTE;
                w_is_sb = 1'b1;
            end
            F3_SH: begin
                w_rep = {2{i_wdata[15:0]}};
                w_be  = BE_HALF;
            end
            default: ;
        endcase
    end

    assign o_mask8 = {4'b0000, w_be} << i_off;
    // Any enable landing in the upper nibble means the store crosses into the next word.
    assign o_split = |o_mask8[7:4];

`ifdef RISCV_STORE_SPLIT_EN
    logic [63:0] w_shift64;
    assign w_shift64 = {32'b0, w_rep} << {i_off, 3'b000};
    assign o_hi_word = w_shift64[63:32];
    assign o_lo_word = w_is_sb ? w_rep : w_shift64[31:0];
`else
    assign o_lo_word = w_is_sb ? w_rep : (w_rep << {i_off, 3'b000});
`endif

endmodule

// File: rtl/riscv_store_align.sv
// Store aligner: captures SB/SH/SW from MEM, drives registered req/gnt memory write beats, stalls until done.
// Optional two-beat split of word-crossing stores under RISCV_STORE_SPLIT_EN; otherwise they are rejected via st_err.
module riscv_store_align
    import riscv_lsu_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  st_busy,
    output logic                  st_done,
    output logic                  st_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be
);

    st_state_t             r_state, w_nxt_state;
    logic                  r_req, w_nxt_req;
    logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_nxt_wdata;
    logic [3:0]            r_be, w_nxt_be;
    logic                  r_err, w_nxt_err;

    logic [DATA_WIDTH-1:0] w_lo;
    logic [7:0]            w_mask8;
    logic                  w_split;
    logic                  w_legal_f3;
    logic                  w_ok;

`ifdef RISCV_STORE_SPLIT_EN
    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [3:0]            r_be_hi;
    logic                  r_split;
`endif

    riscv_store_lane u_lane (
        .i_funct3  (funct3),
        .i_off     (addr[1:0]),
        .i_wdata   (wdata),
`ifdef RISCV_STORE_SPLIT_EN
        .o_hi_word (w_hi),
`endif
        .o_lo_word (w_lo),
        .o_mask8   (w_mask8),
        .o_split   (w_split)
    );

    assign w_legal_f3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
`ifdef RISCV_STORE_SPLIT_EN
    assign w_ok = w_legal_f3;
`else
    assign w_ok = w_legal_f3 && !w_split;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_req   = r_req;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_nxt_be    = r_be;
        w_nxt_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (st_valid) begin
                    if (w_ok) begin
                        w_nxt_state = S_BEAT0;
                        w_nxt_req   = 1'b1;
                        w_nxt_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        w_nxt_wdata = w_lo;
                        w_nxt_be    = w_mask8[3:0];
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_gnt) begin
`ifdef RISCV_STORE_SPLIT_EN
                    if (r_split) begin
                        w_nxt_state = S_BEAT1;
                        w_nxt_addr  = r_addr + ADDR_WIDTH'(4);
                        w_nxt_wdata = r_hi;
                        w_nxt_be    = r_be_hi;
                    end else
`endif
                    begin
                        w_nxt_state = S_DONE;
                        w_nxt_req   = 1'b0;
                    end
                end
            end
`ifdef RISCV_STORE_SPLIT_EN
            S_BEAT1: begin
                if (mem_gnt) begin
                    w_nxt_state = S_DONE;
                    w_nxt_req   = 1'b0;
                end
            end
`endif
            S_DONE:  w_nxt_state = S_IDLE;
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_req   <= w_nxt_req;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_be    <= w_nxt_be;
            r_err   <= w_nxt_err;
        end
    end

`ifdef RISCV_STORE_SPLIT_EN
    // Second-beat fields are held from accept until BEAT0 is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_be_hi <= '0;
            r_split <= 1'b0;
        end else if (st_valid && r_state == S_IDLE && w_ok) begin
            r_hi    <= w_hi;
            r_be_hi <= w_mask8[7:4];
            r_split <= w_split;
        end
    end
`endif

    assign st_ready  = (r_state == S_IDLE);
    assign st_busy   = (r_state != S_IDLE);
    assign st_done   = (r_state == S_DONE);
    assign st_err    = r_err;
    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule
